// File: rtl/bcd_display_scanner.sv
// Time-multiplexed BCD scanner for a multi-digit 7-segment display, with anti-ghosting
// guard interval and leading-zero blanking. Optional blink feature: define BCD_SCAN_BLINK_EN.
module bcd_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic                          load,
    input  logic                          blank_lz,
`ifdef BCD_SCAN_BLINK_EN
    input  logic                          blink,
`endif
    output logic [3:0]                    bcd,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          invalid
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_END = PW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        S_GUARD = 1'b0,
        S_ON    = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] latch_q, latch_d;
    logic [3:0]              bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    invalid_q, invalid_d;

    logic                    presc_wrap;
    logic                    zero_above;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   bad_mask;
    logic                    suppressed;
    logic                    blink_off;

`ifdef BCD_SCAN_BLINK_EN
    logic [5:0] frame_q, frame_d;
    logic       phase_q, phase_d;
    logic       frame_wrap;

    always_comb begin
        frame_wrap = presc_wrap && (idx_q == IDX_MAX);
        frame_d    = frame_q;
        phase_d    = phase_q;
        if (frame_wrap) begin
            frame_d = frame_q + 6'd1;
            if (frame_q == 6'd63) begin
                phase_d = ~phase_q;
            end
        end
        blink_off = blink & phase_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end
`else
    always_comb begin
        blink_off = 1'b0;
    end
`endif

    // All outputs are computed from next-cycle scan position and latch contents so the
    // registered outputs line up with digit_idx and reflect a load on the following cycle.
    always_comb begin
        presc_wrap = (presc_q == PRESC_MAX);
        presc_d    = presc_wrap ? '0 : presc_q + 1'b1;

        idx_d = idx_q;
        if (presc_wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        latch_d = load ? digits_in : latch_q;

        state_d = state_q;
        case (state_q)
            S_GUARD: if (GUARD_CYCLES == 0 || presc_d == GUARD_END) state_d = S_ON;
            S_ON:    if (presc_wrap && GUARD_CYCLES != 0) state_d = S_GUARD;
            default: state_d = S_GUARD;
        endcase

        // Scan from the most significant digit down; a digit is a leading zero while
        // every digit at or above it is zero. Digit 0 always displays.
        zero_above = 1'b1;
        lz_mask    = '0;
        bad_mask   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above  = zero_above & (latch_d[4*i +: 4] == 4'd0);
            lz_mask[i]  = zero_above & (i != 0);
            bad_mask[i] = (latch_d[4*i +: 4] > 4'd9);
        end

        suppressed = bad_mask[idx_d] | (blank_lz & lz_mask[idx_d]);
        bcd_d      = latch_d[4*int'(idx_d) +: 4];
        invalid_d  = |bad_mask;

        sel_d = '1;
        if (state_d == S_ON && !suppressed && !blink_off) begin
            sel_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_GUARD;
            presc_q   <= '0;
            idx_q     <= '0;
            latch_q   <= '0;
            bcd_q     <= 4'd0;
            sel_q     <= '1;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            latch_q   <= latch_d;
            bcd_q     <= bcd_d;
            sel_q     <= sel_d;
            invalid_q <= invalid_d;
        end
    end

    assign bcd       = bcd_q;
    assign digit_sel = sel_q;
    assign digit_idx = idx_q;
    assign invalid   = invalid_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner (4 digits, 4-cycle slots, 1 guard cycle):
// vector table, directed corner sequences and a randomized run against a reference model.
module tb_bcd_display_scanner;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int GC = 1;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  bcd;
    logic [3:0]  digit_sel;
    logic [1:0]  digit_idx;
    logic        invalid;

    int tests_run;
    int tests_failed;

    bcd_display_scanner #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .GUARD_CYCLES(GC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .digits_in(digits_in),
        .load     (load),
        .blank_lz (blank_lz),
        .bcd      (bcd),
        .digit_sel(digit_sel),
        .digit_idx(digit_idx),
        .invalid  (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: cycles elapsed since reset release plus the latched digits.
    int          m_t;
    int          m_lat[ND];
    logic        m_blz;
    logic [15:0] cur_din;

    function automatic int m_presc();
        return m_t % RD;
    endfunction

    function automatic int m_idx();
        return (m_t / RD) % ND;
    endfunction

    function automatic logic m_suppressed(input int i);
        logic all_zero;
        if (m_lat[i] > 9) return 1'b1;
        if (!m_blz || i == 0) return 1'b0;
        all_zero = 1'b1;
        for (int j = i; j < ND; j++) begin
            if (m_lat[j] != 0) all_zero = 1'b0;
        end
        return all_zero;
    endfunction

    function automatic logic [3:0] m_sel();
        logic [3:0] s;
        s = 4'b1111;
        if (m_presc() >= GC && !m_suppressed(m_idx())) s[m_idx()] = 1'b0;
        return s;
    endfunction

    function automatic logic m_invalid();
        for (int i = 0; i < ND; i++) begin
            if (m_lat[i] > 9) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    task automatic model_reset();
        m_t = 0;
        for (int i = 0; i < ND; i++) m_lat[i] = 0;
    endtask

    // Drive one clock's worth of inputs, advance the model across the edge, settle at +1.
    task automatic apply(input logic ld, input logic [15:0] din, input logic blz);
        load      = ld;
        cur_din   = din;
        digits_in = din;
        blank_lz  = blz;
        @(posedge clk);
        if (ld) begin
            for (int i = 0; i < ND; i++) m_lat[i] = int'((din >> (4 * i)) & 16'hF);
        end
        m_blz = blz;
        m_t++;
        #1;
        load = 1'b0;
    endtask

    task automatic check_model();
        chk("model_idx", 32'(digit_idx), 32'(m_idx()));
        chk("model_bcd", 32'(bcd), 32'(m_lat[m_idx()]));
        chk("model_sel", 32'(digit_sel), 32'(m_sel()));
        chk("model_invalid", 32'(invalid), 32'(m_invalid()));
    endtask

    task automatic step(input logic ld, input logic [15:0] din, input logic blz);
        apply(ld, din, blz);
        check_model();
    endtask

    task automatic run_to(input int idx, input int presc, input logic blz);
        for (int n = 0; n < 64 && !(m_idx() == idx && m_presc() == presc); n++) begin
            step(1'b0, cur_din, blz);
        end
    endtask

    typedef struct {
        logic        ld;
        logic [15:0] din;
        logic        blz;
        logic [3:0]  e_bcd;
        logic [3:0]  e_sel;
        logic [1:0]  e_idx;
        logic        e_inv;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic ld, input logic [15:0] din, input logic [3:0] b,
                                input logic [3:0] s, input logic [1:0] ix);
        vec_t v;
        v.ld    = ld;
        v.din   = din;
        v.blz   = 1'b0;
        v.e_bcd = b;
        v.e_sel = s;
        v.e_idx = ix;
        v.e_inv = 1'b0;
        return v;
    endfunction

    initial begin
        logic       ld;
        logic [15:0] din;
        logic [3:0] nib;
        int         r;
        logic       blz;

        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        load         = 1'b0;
        digits_in    = 16'h0;
        cur_din      = 16'h0;
        blank_lz     = 1'b0;
        m_blz        = 1'b0;
        model_reset();

        vecs[0]  = mk(1'b1, 16'h1234, 4'd4, 4'b1110, 2'd0);
        vecs[1]  = mk(1'b0, 16'h1234, 4'd4, 4'b1110, 2'd0);
        vecs[2]  = mk(1'b0, 16'h1234, 4'd3, 4'b1111, 2'd1);
        vecs[3]  = mk(1'b0, 16'h1234, 4'd3, 4'b1101, 2'd1);
        vecs[4]  = mk(1'b0, 16'h1234, 4'd3, 4'b1101, 2'd1);
        vecs[5]  = mk(1'b0, 16'h1234, 4'd3, 4'b1101, 2'd1);
        vecs[6]  = mk(1'b0, 16'h1234, 4'd2, 4'b1111, 2'd2);
        vecs[7]  = mk(1'b0, 16'h1234, 4'd2, 4'b1011, 2'd2);
        vecs[8]  = mk(1'b0, 16'h1234, 4'd2, 4'b1011, 2'd2);
        vecs[9]  = mk(1'b0, 16'h1234, 4'd2, 4'b1011, 2'd2);
        vecs[10] = mk(1'b0, 16'h1234, 4'd1, 4'b1111, 2'd3);
        vecs[11] = mk(1'b0, 16'h1234, 4'd1, 4'b0111, 2'd3);
        vecs[12] = mk(1'b0, 16'h1234, 4'd1, 4'b0111, 2'd3);
        vecs[13] = mk(1'b0, 16'h1234, 4'd1, 4'b0111, 2'd3);
        vecs[14] = mk(1'b0, 16'h1234, 4'd4, 4'b1111, 2'd0);
        vecs[15] = mk(1'b0, 16'h1234, 4'd4, 4'b1110, 2'd0);

        // Reset state while held.
        #12;
        chk("reset_sel", 32'(digit_sel), 32'hF);
        chk("reset_bcd", 32'(bcd), 32'h0);
        chk("reset_idx", 32'(digit_idx), 32'h0);
        chk("reset_invalid", 32'(invalid), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_guard_sel", 32'(digit_sel), 32'h F);
        step(1'b0, 16'h0000, 1'b0);
        chk("release_on_sel", 32'(digit_sel), 32'h E);

        // Full scan of 1234 from the vector table.
        foreach (vecs[k]) begin
            apply(vecs[k].ld, vecs[k].din, vecs[k].blz);
            chk($sformatf("vec%0d_bcd", k), 32'(bcd), 32'(vecs[k].e_bcd));
            chk($sformatf("vec%0d_sel", k), 32'(digit_sel), 32'(vecs[k].e_sel));
            chk($sformatf("vec%0d_idx", k), 32'(digit_idx), 32'(vecs[k].e_idx));
            chk($sformatf("vec%0d_inv", k), 32'(invalid), 32'(vecs[k].e_inv));
        end

        // Leading-zero blanking on 0070.
        step(1'b1, 16'h0070, 1'b1);
        run_to(3, 2, 1'b1);
        chk("blank_slot3_sel", 32'(digit_sel), 32'h F);
        run_to(2, 2, 1'b1);
        chk("blank_slot2_sel", 32'(digit_sel), 32'h F);
        run_to(1, 2, 1'b1);
        chk("blank_slot1_bcd", 32'(bcd), 32'h7);
        chk("blank_slot1_sel", 32'(digit_sel), 32'h D);
        run_to(0, 2, 1'b1);
        chk("blank_slot0_bcd", 32'(bcd), 32'h0);
        chk("blank_slot0_sel", 32'(digit_sel), 32'h E);
        run_to(3, 2, 1'b0);
        chk("noblank_slot3_sel", 32'(digit_sel), 32'h7);
        run_to(2, 2, 1'b0);
        chk("noblank_slot2_sel", 32'(digit_sel), 32'h B);

        // Invalid digit handling.
        step(1'b1, 16'h00A5, 1'b0);
        chk("invalid_set", 32'(invalid), 32'h1);
        run_to(1, 2, 1'b0);
        chk("invalid_slot1_bcd", 32'(bcd), 32'h A);
        chk("invalid_slot1_sel", 32'(digit_sel), 32'h F);
        step(1'b1, 16'h0005, 1'b0);
        chk("invalid_clear", 32'(invalid), 32'h0);

        // Load coincident with the slot-0 terminal count.
        run_to(0, 3, 1'b0);
        step(1'b1, 16'h9999, 1'b0);
        chk("wrapload_idx", 32'(digit_idx), 32'h1);
        chk("wrapload_bcd", 32'(bcd), 32'h9);
        chk("wrapload_guard_sel", 32'(digit_sel), 32'h F);
        step(1'b0, 16'h9999, 1'b0);
        chk("wrapload_on_sel", 32'(digit_sel), 32'h D);
        step(1'b0, 16'h9999, 1'b0);
        step(1'b0, 16'h9999, 1'b0);
        chk("wrapload_still_slot1", 32'(digit_idx), 32'h1);
        step(1'b0, 16'h9999, 1'b0);
        chk("wrapload_next_slot", 32'(digit_idx), 32'h2);

        // Asynchronous reset in the middle of an ON cycle of slot 2.
        run_to(2, 2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_sel", 32'(digit_sel), 32'h F);
        chk("midreset_bcd", 32'(bcd), 32'h0);
        chk("midreset_idx", 32'(digit_idx), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 16'h0000, 1'b0);
        chk("midreset_slot0_bcd", 32'(bcd), 32'h0);
        chk("midreset_slot0_sel", 32'(digit_sel), 32'h E);

        // Randomized run against the model; zero-biased digits exercise blanking.
        blz = 1'b0;
        for (int c = 0; c < 400; c++) begin
            ld = ($urandom_range(0, 5) == 0);
            din = 16'h0;
            for (int i = 0; i < ND; i++) begin
                r = int'($urandom_range(0, 19));
                nib = (r < 8) ? 4'd0 : (r < 18) ? 4'(r - 8) : 4'(r - 8);
                din[4*i +: 4] = nib;
            end
            if ($urandom_range(0, 15) == 0) blz = ~blz;
            step(ld, ld ? din : cur_din, blz);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
